// File: rtl/mips_run_ctrl_pkg.sv
// Shared definitions for the MIPS run-control sequencer.
// Contents:
//   rc_cmd_e    host/debug command opcodes
//   rc_state_e  sequencer states, numbered as seen on the state output
//   helpers     decode pipeline-enable and PC-hold from a state
package mips_run_ctrl_pkg;

  typedef enum logic [2:0] {
    CmdNop   = 3'd0,
    CmdRun   = 3'd1,
    CmdStep  = 3'd2,
    CmdBreak = 3'd3,
    CmdClear = 3'd4
  } rc_cmd_e;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRun    = 3'd1,
    StStep   = 3'd2,
    StDrain  = 3'd3,
    StPaused = 3'd4,
    StHalted = 3'd5
  } rc_state_e;

  function automatic logic st_pipe_en(rc_state_e s);
    return (s == StRun) || (s == StStep) || (s == StDrain);
  endfunction

  function automatic logic st_pc_hold(rc_state_e s);
    return (s == StDrain) || (s == StHalted);
  endfunction

endpackage

// File: rtl/mips_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk      clock
//   reset    synchronous active-low reset
//   en_i     increment this cycle (holds at all-ones)
//   clr_i    zero the count; wins over en_i
//   count_o  registered count
module mips_run_ctrl_sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != {Width{1'b1}})) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mips_run_ctrl.sv
// Run-control sequencer for the 5-stage MIPS pipeline. Gates the global pipeline
// enable from host/debug commands (run, N-cycle step, break, clear) and drains
// the pipeline after a HALT is fetched so older instructions retire first.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   cmd_valid/ready       command handshake; cmd_op opcode, cmd_arg step count
//   halt_if               instruction in IF is HALT
//   wb_retire             real instruction committing in WB
//   pipe_en, pc_hold      pipeline enable, PC freeze (registered)
//   pipe_flush, done      one-cycle pulses (registered)
//   state                 current sequencer state
//   cycle_cnt, retire_cnt saturating counters since last CLEAR
module mips_run_ctrl
  import mips_run_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned STEP_W       = 16,
  parameter int unsigned CNT_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_arg,
  input  logic              halt_if,
  input  logic              wb_retire,
  output logic              pipe_en,
  output logic              pc_hold,
  output logic              pipe_flush,
  output logic [2:0]        state,
  output logic              done,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  retire_cnt
);

  rc_state_e         state_q, state_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic              pipe_en_q, pc_hold_q, pipe_flush_q, done_q;
  logic              cmd_fire, halt_seen, clear;

  assign cmd_ready = (state_q != StDrain) && !pipe_flush_q;
  assign cmd_fire  = cmd_valid && cmd_ready;
  // pc_hold_q masks a HALT still sitting in IF once the PC is frozen.
  assign halt_seen = halt_if && pipe_en_q && !pc_hold_q;
  assign clear     = cmd_fire && (cmd_op == CmdClear);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StPaused: begin
          if (cmd_fire && (cmd_op == CmdRun)) begin
            state_d = StRun;
          end else if (cmd_fire && (cmd_op == CmdStep)) begin
            state_d = StStep;
            cnt_d   = (cmd_arg == '0) ? STEP_W'(1) : cmd_arg;
          end
        end
        StRun: begin
          if (cmd_fire && (cmd_op == CmdBreak)) begin
            state_d = StPaused;
          end else if (halt_seen) begin
            state_d = StDrain;
            cnt_d   = STEP_W'(DRAIN_CYCLES);
          end
        end
        StStep: begin
          // Command beats halt, halt beats step expiry.
          if (cmd_fire && (cmd_op == CmdBreak)) begin
            state_d = StPaused;
          end else if (halt_seen) begin
            state_d = StDrain;
            cnt_d   = STEP_W'(DRAIN_CYCLES);
          end else if (cnt_q == STEP_W'(1)) begin
            state_d = StPaused;
          end else begin
            cnt_d = cnt_q - STEP_W'(1);
          end
        end
        StDrain: begin
          if (cnt_q == STEP_W'(1)) begin
            state_d = StHalted;
          end else begin
            cnt_d = cnt_q - STEP_W'(1);
          end
        end
        StHalted: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      pipe_en_q    <= 1'b0;
      pc_hold_q    <= 1'b0;
      pipe_flush_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pipe_en_q    <= st_pipe_en(state_d);
      pc_hold_q    <= st_pc_hold(state_d);
      pipe_flush_q <= clear;
      done_q       <= (state_d != state_q) &&
                      ((state_d == StPaused) || (state_d == StHalted));
    end
  end

  assign pipe_en    = pipe_en_q;
  assign pc_hold    = pc_hold_q;
  assign pipe_flush = pipe_flush_q;
  assign done       = done_q;
  assign state      = state_q;

  mips_run_ctrl_sat_counter #(
    .Width (CNT_W)
  ) u_cycle_cnt (
    .clk     (clk),
    .reset   (reset),
    .en_i    (pipe_en_q),
    .clr_i   (clear),
    .count_o (cycle_cnt)
  );

  mips_run_ctrl_sat_counter #(
    .Width (CNT_W)
  ) u_retire_cnt (
    .clk     (clk),
    .reset   (reset),
    .en_i    (pipe_en_q && wb_retire),
    .clr_i   (clear),
    .count_o (retire_cnt)
  );

endmodule

// File: tb/tb_mips_run_ctrl.sv
module tb_mips_run_ctrl;

  localparam int ST_IDLE = 0, ST_RUN = 1, ST_STEP = 2, ST_DRAIN = 3, ST_PAUSED = 4,
                 ST_HALTED = 5;
  localparam logic [2:0] OP_NOP = 3'd0, OP_RUN = 3'd1, OP_STEP = 3'd2, OP_BREAK = 3'd3,
                         OP_CLEAR = 3'd4;
  localparam int DRAIN = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = 3'd0;
  logic [15:0] cmd_arg = 16'd0;
  logic        halt_if = 1'b0;
  logic        wb_retire = 1'b0;

  logic        a_ready, a_en, a_hold, a_flush, a_done;
  logic [2:0]  a_state;
  logic [31:0] a_cyc, a_ret;
  logic        b_ready, b_en, b_hold, b_flush, b_done;
  logic [2:0]  b_state;
  logic [3:0]  b_cyc, b_ret;

  always #5 clk = ~clk;

  mips_run_ctrl #(.DRAIN_CYCLES(4), .STEP_W(16), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(a_ready), .cmd_op(cmd_op),
    .cmd_arg(cmd_arg), .halt_if(halt_if), .wb_retire(wb_retire), .pipe_en(a_en),
    .pc_hold(a_hold), .pipe_flush(a_flush), .state(a_state), .done(a_done),
    .cycle_cnt(a_cyc), .retire_cnt(a_ret)
  );

  mips_run_ctrl #(.DRAIN_CYCLES(4), .STEP_W(16), .CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(b_ready), .cmd_op(cmd_op),
    .cmd_arg(cmd_arg), .halt_if(halt_if), .wb_retire(wb_retire), .pipe_en(b_en),
    .pc_hold(b_hold), .pipe_flush(b_flush), .state(b_state), .done(b_done),
    .cycle_cnt(b_cyc), .retire_cnt(b_ret)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode, remaining enabled cycles, unbounded counters.
  int     m_st = ST_IDLE;
  int     m_rem = 0;
  bit     m_flush = 0, m_done = 0;
  longint m_cyc = 0, m_ret = 0;

  function automatic bit m_en();
    return (m_st == ST_RUN) || (m_st == ST_STEP) || (m_st == ST_DRAIN);
  endfunction

  function automatic bit m_hold();
    return (m_st == ST_DRAIN) || (m_st == ST_HALTED);
  endfunction

  function automatic bit m_ready();
    return (m_st != ST_DRAIN) && !m_flush;
  endfunction

  function automatic longint sat(longint v, int bits);
    longint mx = (longint'(1) << bits) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_edge(bit r, bit cv, logic [2:0] op, logic [15:0] arg, bit halt,
                            bit ret);
    bit fire, clr, halt_seen;
    int nst;
    if (!r) begin
      m_st = ST_IDLE; m_rem = 0; m_flush = 0; m_done = 0; m_cyc = 0; m_ret = 0;
      return;
    end
    fire      = cv && m_ready();
    clr       = fire && (op == OP_CLEAR);
    halt_seen = halt && m_en() && !m_hold();
    if (clr) begin
      m_cyc = 0; m_ret = 0;
    end else if (m_en()) begin
      m_cyc++;
      if (ret) m_ret++;
    end
    nst = m_st;
    if (clr) nst = ST_IDLE;
    else if (m_st == ST_IDLE || m_st == ST_PAUSED) begin
      if (fire && op == OP_RUN) nst = ST_RUN;
      else if (fire && op == OP_STEP) begin
        nst = ST_STEP; m_rem = (arg == 0) ? 1 : int'(arg);
      end
    end else if (m_st == ST_RUN || m_st == ST_STEP) begin
      if (fire && op == OP_BREAK) nst = ST_PAUSED;
      else if (halt_seen) begin
        nst = ST_DRAIN; m_rem = DRAIN;
      end else if (m_st == ST_STEP) begin
        m_rem--;
        if (m_rem == 0) nst = ST_PAUSED;
      end
    end else if (m_st == ST_DRAIN) begin
      m_rem--;
      if (m_rem == 0) nst = ST_HALTED;
    end
    m_done  = (nst != m_st) && (nst == ST_PAUSED || nst == ST_HALTED);
    m_flush = clr;
    m_st    = nst;
  endtask

  task automatic compare_all();
    check_eq("state", 64'(a_state), 64'(m_st));
    check_eq("pipe_en", 64'(a_en), 64'(m_en()));
    check_eq("pc_hold", 64'(a_hold), 64'(m_hold()));
    check_eq("pipe_flush", 64'(a_flush), 64'(m_flush));
    check_eq("done", 64'(a_done), 64'(m_done));
    check_eq("cmd_ready", 64'(a_ready), 64'(m_ready()));
    check_eq("cycle_cnt", 64'(a_cyc), 64'(sat(m_cyc, 32)));
    check_eq("retire_cnt", 64'(a_ret), 64'(sat(m_ret, 32)));
    check_eq("s_state", 64'(b_state), 64'(m_st));
    check_eq("s_ctl", {60'd0, b_en, b_hold, b_flush, b_done},
             {60'd0, m_en(), m_hold(), m_flush, m_done});
    check_eq("s_ready", 64'(b_ready), 64'(m_ready()));
    check_eq("s_cycle_cnt", 64'(b_cyc), 64'(sat(m_cyc, 4)));
    check_eq("s_retire_cnt", 64'(b_ret), 64'(sat(m_ret, 4)));
  endtask

  // Drive one cycle of inputs, clock it, then compare #1 after the edge.
  task automatic cyc(bit r, bit cv, logic [2:0] op, logic [15:0] arg, bit halt, bit ret);
    reset = r; cmd_valid = cv; cmd_op = op; cmd_arg = arg; halt_if = halt; wb_retire = ret;
    @(posedge clk);
    model_edge(r, cv, op, arg, halt, ret);
    #1;
    compare_all();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(1, 0, OP_NOP, 16'd0, 0, 0);
  endtask

  initial begin
    int en_cycles;
    // 1: reset
    cyc(0, 0, OP_NOP, 16'd0, 0, 0);
    cyc(0, 0, OP_NOP, 16'd0, 0, 0);
    check_eq("rst_state", 64'(a_state), 64'd0);
    check_eq("rst_pipe_en", 64'(a_en), 64'd0);
    check_eq("rst_ready", 64'(a_ready), 64'd1);
    check_eq("rst_counts", 64'(a_cyc) + 64'(a_ret), 64'd0);

    // 2: STEP 3
    en_cycles = 0;
    cyc(1, 1, OP_STEP, 16'd3, 0, 0); en_cycles += int'(a_en);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, OP_NOP, 16'd0, 0, 0); en_cycles += int'(a_en);
    end
    check_eq("step3_en_cycles", 64'(en_cycles), 64'd3);
    check_eq("step3_state", 64'(a_state), 64'd4);
    check_eq("step3_done", 64'(a_done), 64'd1);
    check_eq("step3_cycle_cnt", 64'(a_cyc), 64'd3);

    // 3: STEP 0 behaves as 1
    en_cycles = 0;
    cyc(1, 1, OP_STEP, 16'd0, 0, 0); en_cycles += int'(a_en);
    cyc(1, 0, OP_NOP, 16'd0, 0, 0); en_cycles += int'(a_en);
    check_eq("step0_en_cycles", 64'(en_cycles), 64'd1);
    check_eq("step0_state", 64'(a_state), 64'd4);
    cyc(1, 1, OP_CLEAR, 16'd0, 0, 0);
    check_eq("clr_flush", 64'(a_flush), 64'd1);
    check_eq("clr_ready", 64'(a_ready), 64'd0);
    idle(1);

    // 4: RUN, HALT in the 10th enabled cycle
    cyc(1, 1, OP_RUN, 16'd0, 0, 0);
    idle(9);
    en_cycles = 0;
    cyc(1, 0, OP_NOP, 16'd0, 1, 0); en_cycles += int'(a_en);
    check_eq("halt_pc_hold", 64'(a_hold), 64'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, OP_NOP, 16'd0, 0, 0); en_cycles += int'(a_en);
    end
    check_eq("drain_en_cycles", 64'(en_cycles), 64'd4);
    check_eq("halted_state", 64'(a_state), 64'd5);
    check_eq("halted_done", 64'(a_done), 64'd1);
    check_eq("halted_cycle_cnt", 64'(a_cyc), 64'd14);
    cyc(1, 1, OP_RUN, 16'd0, 0, 0);
    check_eq("halted_ignores_run", 64'(a_state), 64'd5);
    cyc(1, 1, OP_CLEAR, 16'd0, 0, 0);
    idle(1);

    // 5: RUN with retire every cycle, BREAK after 20
    cyc(1, 1, OP_RUN, 16'd0, 0, 1);
    for (int i = 0; i < 19; i++) cyc(1, 0, OP_NOP, 16'd0, 0, 1);
    cyc(1, 1, OP_BREAK, 16'd0, 0, 1);
    check_eq("break_state", 64'(a_state), 64'd4);
    check_eq("break_retire_cnt", 64'(a_ret), 64'd20);
    cyc(1, 1, OP_CLEAR, 16'd0, 0, 0);
    check_eq("clear_flush", 64'(a_flush), 64'd1);
    check_eq("clear_counts", 64'(a_cyc) + 64'(a_ret), 64'd0);
    idle(1);

    // 6: 4-bit counters saturate; reset during DRAIN
    cyc(1, 1, OP_RUN, 16'd0, 0, 0);
    idle(20);
    check_eq("sat_small_cycle_cnt", 64'(b_cyc), 64'd15);
    check_eq("sat_wide_cycle_cnt", 64'(a_cyc), 64'd20);
    cyc(1, 0, OP_NOP, 16'd0, 1, 0);
    idle(1);
    cyc(0, 0, OP_NOP, 16'd0, 0, 0);
    check_eq("rst_in_drain_state", 64'(a_state), 64'd0);
    check_eq("rst_in_drain_en", 64'(a_en), 64'd0);
    idle(1);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit          r, cv, h, rt;
      logic [2:0]  op;
      logic [15:0] arg;
      r   = ($urandom_range(0, 99) != 0);
      cv  = ($urandom_range(0, 4) == 0);
      op  = 3'($urandom_range(0, 7));
      arg = ($urandom_range(0, 9) < 8) ? 16'($urandom_range(0, 6)) : 16'($urandom);
      h   = ($urandom_range(0, 19) == 0);
      rt  = ($urandom_range(0, 1) == 1);
      cyc(r, cv, op, arg, h, rt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
